// File: rtl/icu_pkg.sv
// icu_pkg: shared opcodes, jump sub-codes, ALU ops, FSM encoding and flag indices
package icu_pkg;
   localparam logic [3:0] OP_MOV_RR = 4'h0;
   localparam logic [3:0] OP_MOV_RI = 4'h1;
   localparam logic [3:0] OP_MOV_RM = 4'h2;
   localparam logic [3:0] OP_MOV_MR = 4'h3;
   localparam logic [3:0] OP_PRNT   = 4'h4;
   localparam logic [3:0] OP_JMP    = 4'h5;
   localparam logic [3:0] OP_NOP    = 4'h6;
   localparam logic [3:0] OP_SYS    = 4'h7;
   localparam logic [3:0] SYS_HLT   = 4'h0;
   localparam logic [3:0] SYS_WAIT  = 4'hF;
   localparam logic [3:0] J_JMP = 4'h0;
   localparam logic [3:0] J_JZ  = 4'h1;
   localparam logic [3:0] J_JNZ = 4'h2;
   localparam logic [3:0] J_JOV = 4'h3;
   localparam logic [3:0] J_JC  = 4'h4;
   typedef enum logic [2:0] {ALU_AND, ALU_OR, ALU_XOR, ALU_ADD, ALU_SUB, ALU_NOT, ALU_SHL, ALU_SHR} alu_op_t;
   localparam logic [2:0] S_FETCH    = 3'd0;
   localparam logic [2:0] S_EXEC     = 3'd1;
   localparam logic [2:0] S_MEM_RD   = 3'd2;
   localparam logic [2:0] S_MEM_WR   = 3'd3;
   localparam logic [2:0] S_WAIT_CNT = 3'd4;
   localparam logic [2:0] S_WAIT_LCD = 3'd5;
   localparam logic [2:0] S_RETIRE   = 3'd6;
   localparam logic [2:0] S_HALT     = 3'd7;
   localparam int FLAG_Z  = 0;
   localparam int FLAG_OV = 1;
   localparam int FLAG_C  = 2;
   // Undefined sub-codes never jump; they are flagged separately.
   function automatic logic jump_taken(input logic [3:0] sub, input logic [2:0] f);
      return (sub == J_JMP) || (sub == J_JZ && f[FLAG_Z]) || (sub == J_JNZ && !f[FLAG_Z]) ||
             (sub == J_JOV && f[FLAG_OV]) || (sub == J_JC && f[FLAG_C]);
   endfunction
endpackage

// File: rtl/instr_ctrl_unit_if.sv
// instr_ctrl_unit_if: PRAM, register file, ALU and LCD signals of the control unit
interface instr_ctrl_unit_if #(parameter int DATA_W = 8, parameter int PC_W = 9, parameter int SRAM_AW = 8);
   logic              instr_valid, instr_ack, instr_done, jmp_en, hlt, lcd_done;
   logic [7:0]        instr_byte;
   logic [DATA_W-1:0] operand1, operand2, reg_a, reg_b, reg_c, reg_d, reg_flags, res;
   logic [1:0]        instr_size, reg_addr;
   logic [PC_W-1:0]   jmp_addr;
   logic [SRAM_AW-1:0] sram_addr;
   logic              rd_en, wr_en, loc_req, strt, reg_we, flags_we, lcd_err, ill_op;
   logic [DATA_W-1:0] lcd_data, data_loc, reg_data, op_1, op_2;
   logic [2:0]        alu_inst;
   modport master (
      input  instr_valid, instr_byte, operand1, operand2, reg_a, reg_b, reg_c, reg_d, reg_flags, res, lcd_done,
      output instr_ack, instr_done, instr_size, jmp_en, jmp_addr, hlt, sram_addr, rd_en, wr_en, lcd_data,
             data_loc, loc_req, strt, reg_data, reg_addr, reg_we, flags_we, alu_inst, op_1, op_2, lcd_err, ill_op
   );
   modport slave (
      output instr_valid, instr_byte, operand1, operand2, reg_a, reg_b, reg_c, reg_d, reg_flags, res, lcd_done,
      input  instr_ack, instr_done, instr_size, jmp_en, jmp_addr, hlt, sram_addr, rd_en, wr_en, lcd_data,
             data_loc, loc_req, strt, reg_data, reg_addr, reg_we, flags_we, alu_inst, op_1, op_2, lcd_err, ill_op
   );
endinterface

// File: rtl/icu_reg_mux.sv
// icu_reg_mux: selects one of the four register file read values
module icu_reg_mux #(parameter int DATA_W = 8) (
   input  logic [1:0]        sel,
   input  logic [DATA_W-1:0] a, b, c, d,
   output logic [DATA_W-1:0] y
);
   assign y = sel[1] ? (sel[0] ? d : c) : (sel[0] ? b : a);
endmodule

// File: rtl/instr_ctrl_unit.sv
// instr_ctrl_unit: multi-cycle fetch/execute/retire controller with SRAM, LCD and ALU sequencing
module instr_ctrl_unit import icu_pkg::*; #(
   parameter int DATA_W      = 8,
   parameter int PC_W        = 9,
   parameter int SRAM_AW     = 8,
   parameter int SRAM_RD_LAT = 1,
   parameter int LCD_TO      = 1024
) (
   input  logic              clk,
   input  logic              sys_rst,
   instr_ctrl_unit_if.master bus,
   inout  wire [DATA_W-1:0]  sram_data
);
   localparam int CNT_W = $clog2(LCD_TO + SRAM_RD_LAT + (1 << DATA_W));
   logic [2:0]        state;
   logic [7:0]        ir;
   logic [DATA_W-1:0] op1_q, op2_q, wdata, rs_val, rd_val, op2_val;
   logic [CNT_W-1:0]  cnt;
   logic              alu_pend, take, drv;
   icu_reg_mux #(.DATA_W(DATA_W)) u_rs  (.sel(ir[1:0]), .a(bus.reg_a), .b(bus.reg_b), .c(bus.reg_c), .d(bus.reg_d), .y(rs_val));
   icu_reg_mux #(.DATA_W(DATA_W)) u_op1 (.sel(ir[3:2]), .a(bus.reg_a), .b(bus.reg_b), .c(bus.reg_c), .d(bus.reg_d), .y(rd_val));
   icu_reg_mux #(.DATA_W(DATA_W)) u_op2 (.sel(ir[1:0]), .a(bus.reg_a), .b(bus.reg_b), .c(bus.reg_c), .d(bus.reg_d), .y(op2_val));
   assign sram_data = drv ? wdata : 'z;
   // Instruction sequencer: every output is a register updated here.
   always_ff @(posedge clk) begin
      if (sys_rst) begin
         state <= S_FETCH; ir <= '0; op1_q <= '0; op2_q <= '0; wdata <= '0; cnt <= '0;
         alu_pend <= 1'b0; take <= 1'b0; drv <= 1'b0;
         bus.instr_ack <= 1'b0; bus.instr_done <= 1'b0; bus.instr_size <= 2'd1; bus.jmp_en <= 1'b0;
         bus.jmp_addr <= '0; bus.hlt <= 1'b0; bus.sram_addr <= '0; bus.rd_en <= 1'b0; bus.wr_en <= 1'b0;
         bus.lcd_data <= '0; bus.data_loc <= '0; bus.loc_req <= 1'b0; bus.strt <= 1'b0; bus.reg_data <= '0;
         bus.reg_addr <= '0; bus.reg_we <= 1'b0; bus.flags_we <= 1'b0; bus.alu_inst <= '0; bus.op_1 <= '0;
         bus.op_2 <= '0; bus.lcd_err <= 1'b0; bus.ill_op <= 1'b0;
      end else begin
         bus.instr_ack <= 1'b0;
         bus.instr_done <= 1'b0;
         bus.jmp_en <= 1'b0;
         bus.reg_we <= 1'b0;
         bus.flags_we <= 1'b0;
         bus.data_loc <= bus.reg_a;
         case (state)
            S_FETCH: if (bus.instr_valid) begin
               ir <= bus.instr_byte;
               op1_q <= bus.operand1;
               op2_q <= bus.operand2;
               take <= 1'b0;
               bus.instr_ack <= 1'b1;
               state <= S_EXEC;
            end
            S_EXEC: begin
               bus.jmp_addr <= PC_W'(op1_q);
               bus.sram_addr <= SRAM_AW'(op1_q);
               bus.reg_addr <= ir[3:2];
               cnt <= '0;
               case (ir[7:4])
                  OP_MOV_RR: begin bus.reg_data <= rs_val; bus.instr_size <= 2'd1; state <= S_RETIRE; end
                  OP_MOV_RI: begin bus.reg_data <= op1_q; bus.instr_size <= 2'd2; state <= S_RETIRE; end
                  OP_MOV_RM: begin bus.rd_en <= 1'b1; bus.instr_size <= 2'd2; state <= S_MEM_RD; end
                  OP_MOV_MR: begin
                     wdata <= rd_val; drv <= 1'b1; bus.wr_en <= 1'b1; bus.instr_size <= 2'd2; state <= S_MEM_WR;
                  end
                  OP_PRNT: begin
                     bus.instr_size <= 2'd2;
                     if (ir[1:0] == 2'b00) begin
                        bus.lcd_data <= rd_val; bus.strt <= 1'b1; bus.loc_req <= 1'b1; state <= S_WAIT_LCD;
                     end else begin
                        bus.rd_en <= 1'b1; state <= S_MEM_RD;
                     end
                  end
                  OP_JMP: begin
                     take <= jump_taken(ir[3:0], bus.reg_flags[2:0]);
                     bus.ill_op <= bus.ill_op | (ir[3:0] > J_JC);
                     bus.instr_size <= 2'd2;
                     state <= S_RETIRE;
                  end
                  OP_NOP: begin bus.instr_size <= 2'd1; state <= S_RETIRE; end
                  OP_SYS: if (ir[3:0] == SYS_HLT) begin
                     bus.hlt <= 1'b1; state <= S_HALT;
                  end else if (ir[3:0] == SYS_WAIT) begin
                     bus.instr_size <= 2'd3; state <= (op1_q == '0) ? S_RETIRE : S_WAIT_CNT;
                  end else begin
                     bus.ill_op <= 1'b1; bus.instr_size <= 2'd1; state <= S_RETIRE;
                  end
                  default: if (!alu_pend) begin
                     bus.alu_inst <= alu_op_t'(ir[6:4]); bus.op_1 <= rd_val; bus.op_2 <= op2_val;
                     bus.instr_size <= 2'd1; alu_pend <= 1'b1;
                  end else begin
                     bus.reg_data <= bus.res; alu_pend <= 1'b0; state <= S_RETIRE;
                  end
               endcase
            end
            S_MEM_RD: if (cnt == CNT_W'(SRAM_RD_LAT - 1)) begin
               bus.rd_en <= 1'b0;
               cnt <= '0;
               if (ir[7:4] == OP_PRNT) begin
                  bus.lcd_data <= sram_data; bus.strt <= 1'b1; bus.loc_req <= 1'b1; state <= S_WAIT_LCD;
               end else begin
                  bus.reg_data <= sram_data; state <= S_RETIRE;
               end
            end else cnt <= cnt + CNT_W'(1);
            S_MEM_WR: begin drv <= 1'b0; bus.wr_en <= 1'b0; state <= S_RETIRE; end
            S_WAIT_CNT: if (cnt + CNT_W'(1) == CNT_W'(op1_q)) state <= S_RETIRE; else cnt <= cnt + CNT_W'(1);
            S_WAIT_LCD: if ((bus.lcd_done && cnt != '0) || cnt == CNT_W'(LCD_TO - 1)) begin
               bus.strt <= 1'b0;
               bus.loc_req <= 1'b0;
               bus.lcd_err <= bus.lcd_err | !(bus.lcd_done && cnt != '0);
               state <= S_RETIRE;
            end else cnt <= cnt + CNT_W'(1);
            S_RETIRE: begin
               bus.instr_done <= 1'b1;
               bus.jmp_en <= take;
               bus.reg_we <= ir[7] || ir[7:4] == OP_MOV_RR || ir[7:4] == OP_MOV_RI || ir[7:4] == OP_MOV_RM;
               bus.flags_we <= ir[7];
               state <= S_FETCH;
            end
            default: state <= S_HALT;
         endcase
      end
   end
endmodule
